// File: rtl/meas_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : meas_pkg
//  Purpose  : Shared types and defaults for the period-measurement requester
//             (FSM state encoding, result record, channel defaults).
//  Revision : 1.0 - initial release
// ============================================================================
package meas_pkg;

   // Default channel count and count width of the measurement controller.
   localparam int MEAS_NCH   = 5;
   localparam int MEAS_VAL_W = 32;
   localparam int MEAS_SEL_W = $clog2(MEAS_NCH);

   // Requester FSM states, explicit 3-bit encoding.
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      WAIT_DONE = 3'd2,
      CAPTURE   = 3'd3,
      SCAN      = 3'd4,
      PRESENT   = 3'd5
   } meas_req_state_t;

   // One delivered result word; field widths follow the package defaults.
   typedef struct packed {
      logic [MEAS_VAL_W-1:0] count;
      logic [MEAS_SEL_W-1:0] sel;
      logic                  err;
      logic                  timeout;
   } meas_result_t;

endpackage : meas_pkg
`default_nettype wire

// File: rtl/meas_timeout_ctr.sv
`default_nettype none
// ============================================================================
//  Module   : meas_timeout_ctr
//  Purpose  : Clear/enable down-counter for wait-for-response states. A clear
//             reloads TIMEOUT_CYCLES-1; expired_o is high in the cycle the
//             counter sits at zero while enabled, so an enabled wait that
//             starts right after a clear lasts exactly TIMEOUT_CYCLES cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module meas_timeout_ctr #(
   parameter int TIMEOUT_CYCLES = 2**24
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int              CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;

   // Reload on clear, otherwise count down while enabled and stop at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= LOAD;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   assign expired_o = en_i && !clr_i && (cnt_q == '0);

endmodule : meas_timeout_ctr
`default_nettype wire

// File: rtl/meas_requester.sv
`default_nettype none
// ============================================================================
//  Module   : meas_requester
//  Purpose  : Initiator of the period-measurement handshake. Pulses start to
//             the measurement controller, follows its busy line, captures all
//             channel counts, selects the lowest-index (best-resolution) valid
//             channel and offers one result word over valid/ready.
//  Options  : MEAS_AUTO_RESTART_EN - after each accepted result go straight
//             back to START for continuous measurement (trigger ignored).
//  Revision : 1.0 - initial release
// ============================================================================
module meas_requester
   import meas_pkg::*;
#(
   parameter int               NCH            = MEAS_NCH,
   parameter int               VAL_W          = MEAS_VAL_W,
   parameter logic [VAL_W-1:0] SAT_LIMIT      = 32'hFFFF_FFF0,
   parameter int               TIMEOUT_CYCLES = 2**24
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   trigger,
   output logic                   meas_start,
   input  logic                   meas_busy,
   input  logic [NCH*VAL_W-1:0]   meas_val,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [VAL_W-1:0]       res_count,
   output logic [$clog2(NCH)-1:0] res_sel,
   output logic                   res_err,
   output logic                   res_timeout,
   output logic                   active
);

   localparam int SEL_W = $clog2(NCH);

   meas_req_state_t  state_q;
   logic [SEL_W-1:0] idx_q;
   logic [VAL_W-1:0] val_q [NCH];
   meas_result_t     res_q;
   logic             meas_start_q;
   logic             res_valid_q;
   logic             active_q;

   logic             in_wait;
   logic             tmo_clr;
   logic             tmo_expired;
   logic [VAL_W-1:0] cur_val;
   logic             cur_ok;

   // The timeout runs only in the two wait states. It is reloaded everywhere
   // else and on the START->WAIT_DONE edge, so every wait starts fresh.
   assign in_wait = (state_q == START) || (state_q == WAIT_DONE);
   assign tmo_clr = !in_wait || ((state_q == START) && meas_busy);

   meas_timeout_ctr #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     (tmo_clr),
      .en_i      (in_wait),
      .expired_o (tmo_expired)
   );

   // Channel under inspection during SCAN: non-zero and below saturation.
   assign cur_val = val_q[idx_q];
   assign cur_ok  = (cur_val != '0) && (cur_val < SAT_LIMIT);

   // Requester FSM with all outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         res_q        <= '0;
         meas_start_q <= 1'b0;
         res_valid_q  <= 1'b0;
         active_q     <= 1'b0;
         for (int i = 0; i < NCH; i++) begin
            val_q[i] <= '0;
         end
      end else begin
         case (state_q)
            IDLE: begin
               if (trigger) begin
                  state_q       <= START;
                  meas_start_q  <= 1'b1;
                  active_q      <= 1'b1;
                  res_q.err     <= 1'b0;
                  res_q.timeout <= 1'b0;
               end
            end

            START: begin
               // Busy wins over a coincident expiry: the controller did answer.
               if (meas_busy) begin
                  state_q      <= WAIT_DONE;
                  meas_start_q <= 1'b0;
               end else if (tmo_expired) begin
                  state_q       <= PRESENT;
                  meas_start_q  <= 1'b0;
                  res_valid_q   <= 1'b1;
                  res_q.count   <= '0;
                  res_q.sel     <= '0;
                  res_q.err     <= 1'b1;
                  res_q.timeout <= 1'b1;
               end
            end

            WAIT_DONE: begin
               // A single low cycle on busy is already taken as completion.
               if (!meas_busy) begin
                  state_q <= CAPTURE;
               end else if (tmo_expired) begin
                  state_q       <= PRESENT;
                  res_valid_q   <= 1'b1;
                  res_q.count   <= '0;
                  res_q.sel     <= '0;
                  res_q.err     <= 1'b1;
                  res_q.timeout <= 1'b1;
               end
            end

            CAPTURE: begin
               for (int i = 0; i < NCH; i++) begin
                  val_q[i] <= meas_val[i*VAL_W +: VAL_W];
               end
               idx_q   <= '0;
               state_q <= SCAN;
            end

            SCAN: begin
               // Lowest index is the fastest reference, so the first valid hit wins.
               if (cur_ok) begin
                  state_q     <= PRESENT;
                  res_valid_q <= 1'b1;
                  res_q.count <= cur_val;
                  res_q.sel   <= idx_q;
                  res_q.err   <= 1'b0;
               end else if (idx_q == SEL_W'(NCH - 1)) begin
                  state_q     <= PRESENT;
                  res_valid_q <= 1'b1;
                  res_q.count <= '0;
                  res_q.sel   <= '0;
                  res_q.err   <= 1'b1;
               end else begin
                  idx_q <= idx_q + SEL_W'(1);
               end
            end

            PRESENT: begin
               // Result fields are untouched here, so they hold until accepted.
               if (res_ready) begin
                  res_valid_q <= 1'b0;
`ifdef MEAS_AUTO_RESTART_EN
                  state_q       <= START;
                  meas_start_q  <= 1'b1;
                  res_q.err     <= 1'b0;
                  res_q.timeout <= 1'b0;
`else
                  state_q  <= IDLE;
                  active_q <= 1'b0;
`endif
               end
            end

            default: begin
               state_q      <= IDLE;
               meas_start_q <= 1'b0;
               res_valid_q  <= 1'b0;
               active_q     <= 1'b0;
            end
         endcase
      end
   end

   assign meas_start  = meas_start_q;
   assign res_valid   = res_valid_q;
   assign res_count   = res_q.count;
   assign res_sel     = res_q.sel;
   assign res_err     = res_q.err;
   assign res_timeout = res_q.timeout;
   assign active      = active_q;

endmodule : meas_requester
`default_nettype wire

// File: tb/tb_meas_requester.sv
`default_nettype none
// ============================================================================
//  Module   : tb_meas_requester
//  Purpose  : Directed self-checking bench for meas_requester. A second
//             instance with a 16-cycle timeout exercises the abort path.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_meas_requester;

   localparam int NCH   = 5;
   localparam int VAL_W = 32;
   localparam int SEL_W = $clog2(NCH);

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 trigger;
   logic                 meas_start;
   logic                 meas_busy;
   logic [NCH*VAL_W-1:0] meas_val;
   logic                 res_valid;
   logic                 res_ready;
   logic [VAL_W-1:0]     res_count;
   logic [SEL_W-1:0]     res_sel;
   logic                 res_err;
   logic                 res_timeout;
   logic                 active;

   logic                 trigger_t;
   logic                 meas_start_t;
   logic                 meas_busy_t;
   logic                 res_valid_t;
   logic                 res_ready_t;
   logic [VAL_W-1:0]     res_count_t;
   logic [SEL_W-1:0]     res_sel_t;
   logic                 res_err_t;
   logic                 res_timeout_t;
   logic                 active_t;

   int checks = 0;
   int errors = 0;
   int lat;
   int n;

   always #5 clk = ~clk;

   meas_requester dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .trigger     (trigger),
      .meas_start  (meas_start),
      .meas_busy   (meas_busy),
      .meas_val    (meas_val),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_count   (res_count),
      .res_sel     (res_sel),
      .res_err     (res_err),
      .res_timeout (res_timeout),
      .active      (active)
   );

   meas_requester #(.TIMEOUT_CYCLES(16)) dut_t (
      .clk         (clk),
      .rst_n       (rst_n),
      .trigger     (trigger_t),
      .meas_start  (meas_start_t),
      .meas_busy   (meas_busy_t),
      .meas_val    (meas_val),
      .res_valid   (res_valid_t),
      .res_ready   (res_ready_t),
      .res_count   (res_count_t),
      .res_sel     (res_sel_t),
      .res_err     (res_err_t),
      .res_timeout (res_timeout_t),
      .active      (active_t)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   // One measurement with a model controller: busy rises one cycle after
   // start and stays high ~100 cycles. lat counts clock edges from the edge
   // that first samples busy low to the edge that raises res_valid.
   task automatic do_meas(input logic [NCH*VAL_W-1:0] vals, input bit poke, output int l);
      int k;
      @(negedge clk); trigger = 1'b1;
      @(negedge clk); trigger = 1'b0;
      chk("start_after_trigger", meas_start, 1);
      meas_busy = 1'b1;
      @(negedge clk);
      chk("start_drop_on_busy", meas_start, 0);
      if (poke) begin
         trigger = 1'b1;
         @(negedge clk);
         trigger = 1'b0;
      end
      repeat (99) @(negedge clk);
      meas_val  = vals;
      meas_busy = 1'b0;
      @(posedge clk);
      @(negedge clk);
      k = 0;
      while (!res_valid && k < 50) begin
         @(negedge clk);
         k++;
      end
      l = k;
   endtask

   task automatic accept();
      @(negedge clk); res_ready = 1'b1;
      @(negedge clk); res_ready = 1'b0;
      chk("valid_drop_after_accept", res_valid, 0);
   endtask

   initial begin
      rst_n = 1'b0; trigger = 1'b0; meas_busy = 1'b0; meas_val = '0; res_ready = 1'b0;
      trigger_t = 1'b0; meas_busy_t = 1'b0; res_ready_t = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_meas_start", meas_start, 0);
      chk("rst_res_valid",  res_valid,  0);
      chk("rst_flags",      {res_err, res_timeout, active}, 0);
      chk("rst_count_sel",  {res_count, res_sel}, 0);
      chk("rst_t_outputs",  {meas_start_t, res_valid_t, active_t}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // ch0 = 5 is valid -> channel 0, fastest path
      do_meas({32'd0, 32'd0, 32'd0, 32'd1200, 32'd5}, 1'b0, lat);
      chk("t1_latency", lat, 2);
      chk("t1_result", {res_count, res_sel, res_err, res_timeout}, {32'd5, 3'd0, 1'b0, 1'b0});
      chk("t1_active", active, 1);
      // Back-pressure: outputs hold while inputs change underneath.
      meas_val = '1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("t1_hold", {res_valid, res_count, res_sel, res_err, res_timeout},
             {1'b1, 32'd5, 3'd0, 1'b0, 1'b0});
      end
      accept();
`ifdef MEAS_AUTO_RESTART_EN
      chk("auto_restart_start", meas_start, 1);
`else
      chk("t1_back_idle", {meas_start, active}, 0);
`endif

      // ch0=0, ch1 saturated, ch2=0, ch3=77 -> channel 3; trigger poked in WAIT_DONE
      do_meas({32'd9, 32'd77, 32'd0, 32'hFFFF_FFFF, 32'd0}, 1'b1, lat);
      chk("t2_latency", lat, 5);
      chk("t2_result", {res_count, res_sel, res_err, res_timeout}, {32'd77, 3'd3, 1'b0, 1'b0});
      accept();
      repeat (5) @(negedge clk);
      chk("t2_no_second_meas", {meas_start, active, res_valid}, 0);

      // all zero -> error after scanning every channel
      do_meas('0, 1'b0, lat);
      chk("t3_latency", lat, 6);
      chk("t3_result", {res_count, res_sel, res_err, res_timeout}, {32'd0, 3'd0, 1'b1, 1'b0});
      accept();

      // saturation boundary: ch0 == limit invalid, ch1 == limit-1 valid
      do_meas({32'd0, 32'd0, 32'd0, 32'hFFFF_FFEF, 32'hFFFF_FFF0}, 1'b0, lat);
      chk("t4_latency", lat, 3);
      chk("t4_result", {res_count, res_sel, res_err, res_timeout}, {32'hFFFF_FFEF, 3'd1, 1'b0, 1'b0});
      accept();

      // busy already high on START entry; then a single-cycle low pulse
      @(negedge clk);
      meas_val  = {32'd0, 32'd0, 32'd0, 32'd1200, 32'd5};
      meas_busy = 1'b1;
      trigger   = 1'b1;
      @(negedge clk); trigger = 1'b0;
      chk("t5_start_one_cycle", meas_start, 1);
      @(negedge clk);
      chk("t5_start_dropped", {meas_start, active}, 2'b01);
      meas_busy = 1'b0;
      @(posedge clk);
      @(negedge clk);
      meas_busy = 1'b1;
      n = 0;
      while (!res_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("t5_latency", n, 2);
      chk("t5_result", {res_count, res_sel, res_err}, {32'd5, 3'd0, 1'b0});
      accept();
      meas_busy = 1'b0;

      // asynchronous reset in WAIT_DONE, then a normal measurement
      @(negedge clk); trigger = 1'b1;
      @(negedge clk); trigger = 1'b0; meas_busy = 1'b1;
      repeat (4) @(negedge clk);
      chk("t6_active_before_rst", active, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_async_rst_outputs", {meas_start, res_valid, res_err, res_timeout, active, res_count, res_sel}, 0);
      meas_busy = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      do_meas({32'd0, 32'd0, 32'd0, 32'd1200, 32'd5}, 1'b0, lat);
      chk("t6_latency", lat, 2);
      chk("t6_result", {res_count, res_sel, res_err}, {32'd5, 3'd0, 1'b0});
      accept();

      // timeout instance: busy never rises, start held exactly 16 cycles
      @(negedge clk); trigger_t = 1'b1;
      @(negedge clk); trigger_t = 1'b0;
      n = 0;
      while (meas_start_t && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk("t7_start_cycles", n, 16);
      chk("t7_result", {res_valid_t, res_timeout_t, res_err_t, res_count_t, res_sel_t},
          {1'b1, 1'b1, 1'b1, 32'd0, 3'd0});
      @(negedge clk); res_ready_t = 1'b1;
      @(negedge clk); res_ready_t = 1'b0;
      chk("t7_accept", {res_valid_t, active_t}, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_meas_requester
`default_nettype wire
